// File: rtl/ether_tx_pkg.sv
// Shared command codes, controller states and frame-size defaults for the
// ether_tx frame scheduler.
package ether_tx_pkg;

    localparam logic [3:0] ETX_CMD_SETSIZE = 4'd1;
    localparam logic [3:0] ETX_CMD_SETDATA = 4'd2;
    localparam logic [3:0] ETX_CMD_SEND    = 4'd3;
    localparam logic [3:0] ETX_CMD_SETXOR  = 4'd4;

    localparam int MIN_WORDS_DEF = 15;
    localparam int MAX_WORDS_DEF = 380;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_XOR,
        ST_SIZE,
        ST_RDREQ,
        ST_RDWAIT,
        ST_DATA,
        ST_SEND,
        ST_DONE
    } ctrl_state_e;

    // Frames shorter than the Ethernet minimum are zero-padded up to it.
    function automatic logic [8:0] eff_words(input logic [8:0] size, input logic [8:0] min_words);
        return (size < min_words) ? min_words : size;
    endfunction

endpackage

// File: rtl/ether_tx_ctrl_cmd_hs.sv
// One ether_tx command: raise cs, wait for the etx_ready toggle, drop cs.
// Aborts with a timeout pulse if the toggle does not arrive in TIMEOUT_CYC cycles.
module etx_cmd_hs #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  cmd_i,
    input  logic [31:0] data_i,
    input  logic        etx_ready_i,
    output logic        etx_cs_o,
    output logic [3:0]  etx_cmd_o,
    output logic [31:0] etx_data_o,
    output logic        ok_o,
    output logic        timeout_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic          cs_q;
    logic          ready_ref_q;
    logic          ok_q;
    logic          timeout_q;
    logic [3:0]    cmd_q;
    logic [31:0]   data_q;
    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_q        <= 1'b0;
            ready_ref_q <= 1'b0;
            ok_q        <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            ok_q      <= 1'b0;
            timeout_q <= 1'b0;
            if (!cs_q) begin
                if (start_i) begin
                    cs_q        <= 1'b1;
                    cmd_q       <= cmd_i;
                    data_q      <= data_i;
                    ready_ref_q <= etx_ready_i;
                    cnt_q       <= '0;
                end
            end else if (etx_ready_i != ready_ref_q) begin
                cs_q <= 1'b0;
                ok_q <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                cs_q      <= 1'b0;
                timeout_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign etx_cs_o   = cs_q;
    assign etx_cmd_o  = cmd_q;
    assign etx_data_o = data_q;
    assign ok_o       = ok_q;
    assign timeout_o  = timeout_q;

endmodule

// File: rtl/ether_tx_ctrl.sv
// Round-robin frame scheduler for two requesters in front of ether_tx:
// reads the granted buffer and issues SETXOR, SETSIZE, SETDATA..., SEND.
module ether_tx_ctrl
    import ether_tx_pkg::*;
#(
    parameter int MIN_WORDS   = MIN_WORDS_DEF,
    parameter int MAX_WORDS   = MAX_WORDS_DEF,
    parameter int TIMEOUT_CYC = 65535,
    parameter int QUIET_CYC   = 4096
) (
    input  logic        etx_clk,
    input  logic        etx_rst,
    input  logic        r0_req,
    input  logic [8:0]  r0_size,
    input  logic [31:0] r0_xor,
    input  logic [31:0] r0_rd_data,
    output logic        r0_done,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic [8:0]  r1_size,
    input  logic [31:0] r1_xor,
    input  logic [31:0] r1_rd_data,
    output logic        r1_done,
    output logic        r1_err,
    output logic        rd_en,
    output logic [8:0]  rd_addr,
    output logic        grant,
    output logic        busy,
    output logic        etx_cs,
    output logic [3:0]  etx_cmd,
    output logic [31:0] etx_data,
    input  logic        etx_ready
);

    localparam logic [8:0] MIN_W = 9'(MIN_WORDS);
    localparam logic [8:0] MAX_W = 9'(MAX_WORDS);
    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

    ctrl_state_e   state_q;
    logic          last_grant_q;
    logic          grant_q;
    logic          ready_prev_q;
    logic [QW-1:0] quiet_q;
    logic [8:0]    size_q;
    logic [8:0]    eff_size_q;
    logic [8:0]    idx_q;
    logic [8:0]    rd_addr_q;
    logic [31:0]   xor_q;
    logic [31:0]   word_q;
    logic          hs_start_q;
    logic [3:0]    hs_cmd_q;
    logic [31:0]   hs_data_q;
    logic          issued_q;
    logic          rd_en_q;
    logic [1:0]    done_q;
    logic [1:0]    err_q;

    logic          gnt_valid_d;
    logic          gnt_d;
    logic          hs_ok;
    logic          hs_timeout;
    logic [31:0]   rd_word;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt_valid_d = r0_req | r1_req;
        gnt_d       = 1'b0;
        if (r0_req && r1_req) begin
            gnt_d = ~last_grant_q;
        end else if (r1_req) begin
            gnt_d = 1'b1;
        end
    end

    assign rd_word = grant_q ? r1_rd_data : r0_rd_data;

    always_ff @(posedge etx_clk or posedge etx_rst) begin
        if (etx_rst) begin
            state_q      <= ST_INIT;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            ready_prev_q <= 1'b0;
            quiet_q      <= '0;
            size_q       <= '0;
            eff_size_q   <= '0;
            idx_q        <= '0;
            rd_addr_q    <= '0;
            xor_q        <= '0;
            word_q       <= '0;
            hs_start_q   <= 1'b0;
            hs_cmd_q     <= '0;
            hs_data_q    <= '0;
            issued_q     <= 1'b0;
            rd_en_q      <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            hs_start_q <= 1'b0;
            rd_en_q    <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            case (state_q)
                // Wait for etx_ready to settle so an in-flight frame can drain.
                ST_INIT: begin
                    ready_prev_q <= etx_ready;
                    if (etx_ready != ready_prev_q) begin
                        quiet_q <= '0;
                    end else if (quiet_q == QUIET_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        quiet_q <= quiet_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (gnt_valid_d) begin
                        grant_q      <= gnt_d;
                        last_grant_q <= gnt_d;
                        size_q       <= gnt_d ? r1_size : r0_size;
                        xor_q        <= gnt_d ? r1_xor : r0_xor;
                        state_q      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (size_q == '0 || size_q > MAX_W) begin
                        done_q[grant_q] <= 1'b1;
                        err_q[grant_q]  <= 1'b1;
                        state_q         <= ST_DONE;
                    end else begin
                        eff_size_q <= eff_words(size_q, MIN_W);
                        idx_q      <= '0;
                        state_q    <= ST_XOR;
                    end
                end
                ST_XOR, ST_SIZE, ST_DATA, ST_SEND: begin
                    if (!issued_q) begin
                        hs_start_q <= 1'b1;
                        issued_q   <= 1'b1;
                        case (state_q)
                            ST_XOR:  begin hs_cmd_q <= ETX_CMD_SETXOR;  hs_data_q <= xor_q; end
                            ST_SIZE: begin hs_cmd_q <= ETX_CMD_SETSIZE; hs_data_q <= {23'd0, eff_size_q}; end
                            ST_DATA: begin hs_cmd_q <= ETX_CMD_SETDATA; hs_data_q <= word_q; end
                            default: begin hs_cmd_q <= ETX_CMD_SEND;    hs_data_q <= '0; end
                        endcase
                    end else if (hs_ok) begin
                        issued_q <= 1'b0;
                        case (state_q)
                            ST_XOR: state_q <= ST_SIZE;
                            // size >= 1 after CHECK, so word 0 always comes from the buffer.
                            ST_SIZE: begin
                                state_q   <= ST_RDREQ;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= '0;
                            end
                            ST_DATA: begin
                                idx_q <= idx_q + 9'd1;
                                if (idx_q + 9'd1 == eff_size_q) begin
                                    state_q <= ST_SEND;
                                end else if (idx_q + 9'd1 < size_q) begin
                                    state_q   <= ST_RDREQ;
                                    rd_en_q   <= 1'b1;
                                    rd_addr_q <= idx_q + 9'd1;
                                end else begin
                                    word_q <= '0;
                                end
                            end
                            default: begin
                                done_q[grant_q] <= 1'b1;
                                state_q         <= ST_DONE;
                            end
                        endcase
                    end else if (hs_timeout) begin
                        issued_q        <= 1'b0;
                        done_q[grant_q] <= 1'b1;
                        err_q[grant_q]  <= 1'b1;
                        state_q         <= ST_DONE;
                    end
                end
                ST_RDREQ:  state_q <= ST_RDWAIT;
                ST_RDWAIT: begin
                    word_q  <= rd_word;
                    state_q <= ST_DATA;
                end
                ST_DONE:   state_q <= ST_IDLE;
                default:   state_q <= ST_INIT;
            endcase
        end
    end

    etx_cmd_hs #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_cmd_hs (
        .clk_i       (etx_clk),
        .rst_i       (etx_rst),
        .start_i     (hs_start_q),
        .cmd_i       (hs_cmd_q),
        .data_i      (hs_data_q),
        .etx_ready_i (etx_ready),
        .etx_cs_o    (etx_cs),
        .etx_cmd_o   (etx_cmd),
        .etx_data_o  (etx_data),
        .ok_o        (hs_ok),
        .timeout_o   (hs_timeout)
    );

    assign r0_done = done_q[0];
    assign r1_done = done_q[1];
    assign r0_err  = err_q[0];
    assign r1_err  = err_q[1];
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ether_tx_ctrl.sv
// Directed bench for ether_tx_ctrl with a behavioural ether_tx and two
// requester buffers; expected command streams are built independently.
module tb_ether_tx_ctrl;

    localparam int TO     = 300;
    localparam int QC     = 40;
    localparam int MINW   = 15;
    localparam int BUDGET = 4000;

    logic        etx_clk = 1'b0;
    logic        etx_rst;
    logic        r0_req, r1_req;
    logic [8:0]  r0_size, r1_size;
    logic [31:0] r0_xor, r1_xor;
    logic [31:0] r0_rd_data, r1_rd_data;
    logic        r0_done, r0_err, r1_done, r1_err;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic        grant, busy;
    logic        etx_cs;
    logic [3:0]  etx_cmd;
    logic [31:0] etx_data;
    logic        etx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  log_cmd[$];
    logic [31:0] log_data[$];
    int          rd_cnt = 0;
    int          cs_rises = 0;
    int          cs_len = 0;
    int          last_cs_len = 0;
    int          tog_dly = 0;
    logic        cs_prev = 1'b0;
    logic        mute_send = 1'b0;
    logic        rd_pend = 1'b0;
    logic [8:0]  rd_pa = '0;

    ether_tx_ctrl #(
        .MIN_WORDS(MINW), .MAX_WORDS(380), .TIMEOUT_CYC(TO), .QUIET_CYC(QC)
    ) dut (
        .etx_clk(etx_clk), .etx_rst(etx_rst),
        .r0_req(r0_req), .r0_size(r0_size), .r0_xor(r0_xor), .r0_rd_data(r0_rd_data),
        .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_size(r1_size), .r1_xor(r1_xor), .r1_rd_data(r1_rd_data),
        .r1_done(r1_done), .r1_err(r1_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .grant(grant), .busy(busy),
        .etx_cs(etx_cs), .etx_cmd(etx_cmd), .etx_data(etx_data), .etx_ready(etx_ready)
    );

    always #5 etx_clk = ~etx_clk;

    // ether_tx and buffer models, all driven on the falling edge.
    always @(negedge etx_clk) begin
        r0_rd_data = rd_pend ? (32'hA000_0000 | 32'(rd_pa)) : 32'hDEAD_BEEF;
        r1_rd_data = rd_pend ? (32'hB000_0000 | 32'(rd_pa)) : 32'hDEAD_BEEF;
        rd_pend = rd_en;
        rd_pa   = rd_addr;
        if (rd_en) rd_cnt++;
        if (etx_cs) begin
            if (!cs_prev) begin
                cs_len = 1;
                cs_rises++;
                log_cmd.push_back(etx_cmd);
                log_data.push_back(etx_data);
                if (!(mute_send && etx_cmd == 4'd3)) tog_dly = 26;
            end else begin
                cs_len++;
            end
        end else if (cs_prev) begin
            last_cs_len = cs_len;
        end
        cs_prev = etx_cs;
        if (tog_dly > 0) begin
            tog_dly--;
            if (tog_dly == 0) etx_ready = ~etx_ready;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_cmd.delete();
        log_data.delete();
    endtask

    task automatic wait_done(output int who, output logic err, output int lat);
        who = -1;
        err = 1'b0;
        lat = 0;
        while (who < 0 && lat < BUDGET) begin
            @(negedge etx_clk);
            lat++;
            if (r0_done) begin
                who = 0;
                err = r0_err;
            end else if (r1_done) begin
                who = 1;
                err = r1_err;
            end
        end
        check("done_seen", (who >= 0), 1);
    endtask

    task automatic check_frame(input string tag, input int who, input int size, input logic [31:0] x);
        int          eff;
        int          bad;
        logic [31:0] w;
        eff = (size < MINW) ? MINW : size;
        bad = 0;
        check({tag, "_len"}, log_cmd.size(), eff + 3);
        if (log_cmd.size() == eff + 3) begin
            if (log_cmd[0] != 4'd4 || log_data[0] != x) bad++;
            if (log_cmd[1] != 4'd1 || log_data[1] != 32'(eff)) bad++;
            for (int i = 0; i < eff; i++) begin
                w = (i < size) ? ((who == 1 ? 32'hB000_0000 : 32'hA000_0000) | 32'(i)) : 32'h0;
                if (log_cmd[2 + i] != 4'd2 || log_data[2 + i] != w) bad++;
            end
            if (log_cmd[eff + 2] != 4'd3 || log_data[eff + 2] != 32'h0) bad++;
        end else begin
            bad = -1;
        end
        check({tag, "_seq"}, bad, 0);
    endtask

    initial begin
        int   who;
        int   lat;
        int   rises0;
        logic err;

        etx_rst = 1'b1;
        etx_ready = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_size = '0; r1_size = '0;
        r0_xor = '0; r1_xor = '0;
        r0_rd_data = '0; r1_rd_data = '0;
        repeat (3) @(negedge etx_clk);
        check("rst_busy", busy, 1);
        check("rst_ctl", {etx_cs, rd_en, grant, r0_done, r0_err, r1_done, r1_err}, 0);
        check("rst_bus", {etx_cmd, etx_data, rd_addr}, 0);
        etx_rst = 1'b0;

        // r0 single frame, exact minimum-plus-one length
        clear_log();
        rd_cnt = 0;
        r0_size = 9'd16; r0_xor = 32'hFFFF_FFFF; r0_req = 1'b1;
        wait_done(who, err, lat);
        r0_req = 1'b0;
        check("t1_who", who, 0);
        check("t1_err", err, 0);
        check_frame("t1", 0, 16, 32'hFFFF_FFFF);
        check("t1_rd_cnt", rd_cnt, 16);
        @(negedge etx_clk);
        check("t1_busy_idle", busy, 0);

        // r1 short frame, padded to the minimum
        clear_log();
        rd_cnt = 0;
        r1_size = 9'd3; r1_xor = 32'h1234_5678; r1_req = 1'b1;
        wait_done(who, err, lat);
        r1_req = 1'b0;
        check("t2_who", who, 1);
        check("t2_err", err, 0);
        check_frame("t2", 1, 3, 32'h1234_5678);
        check("t2_rd_cnt", rd_cnt, 3);

        // both requesting: grants alternate starting with r0
        r0_size = 9'd1; r1_size = 9'd1;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(who, err, lat);
            check($sformatf("t3_who%0d", k), who, k % 2);
            check($sformatf("t3_grant%0d", k), grant, k % 2);
            check($sformatf("t3_err%0d", k), err, 0);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (2) @(negedge etx_clk);

        // rejected sizes: no commands issued
        rises0 = cs_rises;
        r0_size = 9'd0; r0_req = 1'b1;
        wait_done(who, err, lat);
        r0_req = 1'b0;
        check("t4a_err", {who[0], err}, 2'b01);
        check("t4a_fast", (lat <= 3), 1);
        @(negedge etx_clk);
        r0_size = 9'd381; r0_req = 1'b1;
        wait_done(who, err, lat);
        r0_req = 1'b0;
        check("t4b_err", {who[0], err}, 2'b01);
        check("t4b_fast", (lat <= 3), 1);
        check("t4_no_cs", cs_rises - rises0, 0);

        // SEND never acknowledged: timeout abort, then a clean frame
        mute_send = 1'b1;
        r0_size = 9'd15; r0_xor = 32'h0; r0_req = 1'b1;
        wait_done(who, err, lat);
        r0_req = 1'b0;
        check("t5_who", who, 0);
        check("t5_err", err, 1);
        check("t5_cs_len", last_cs_len, TO);
        check("t5_cs_low", etx_cs, 0);
        mute_send = 1'b0;
        @(negedge etx_clk);
        clear_log();
        r0_size = 9'd2; r0_xor = 32'h5555_AAAA; r0_req = 1'b1;
        wait_done(who, err, lat);
        r0_req = 1'b0;
        check("t5b_err", err, 0);
        check_frame("t5b", 0, 2, 32'h5555_AAAA);

        // reset in the middle of the SETDATA loop
        r0_size = 9'd20; r0_xor = 32'h0BAD_F00D; r0_req = 1'b1;
        lat = 0;
        while (log_cmd.size() < 6 && lat < BUDGET) begin
            @(negedge etx_clk);
            lat++;
        end
        check("t6_midframe", (log_cmd.size() >= 6), 1);
        etx_rst = 1'b1;
        @(negedge etx_clk);
        check("t6_rst_busy", busy, 1);
        check("t6_rst_ctl", {etx_cs, rd_en, grant, r0_done, r0_err, r1_done, r1_err}, 0);
        check("t6_rst_bus", {etx_cmd, etx_data, rd_addr}, 0);
        @(negedge etx_clk);
        etx_rst = 1'b0;
        clear_log();
        r1_size = 9'd2; r1_xor = 32'hC0FF_EE00; r1_req = 1'b1;
        lat = 0;
        while (!etx_cs && lat < QC + BUDGET) begin
            @(negedge etx_clk);
            lat++;
        end
        check("t6_quiet", (lat >= QC), 1);
        wait_done(who, err, lat);
        r0_req = 1'b0;
        check("t6_first_grant", who, 0);
        check("t6_err", err, 0);
        check_frame("t6", 0, 20, 32'h0BAD_F00D);
        clear_log();
        wait_done(who, err, lat);
        r1_req = 1'b0;
        check("t6b_who", who, 1);
        check("t6b_err", err, 0);
        check_frame("t6b", 1, 2, 32'hC0FF_EE00);

        repeat (2) @(negedge etx_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
